spi_mem_port_arbiter: RTL
=========================

# spi_mem_port_arbiter

Shares the single read/write port (port A) of the SPI controller's byte-writable register/buffer memory between two requesters: the host register-bus bridge (requester 0) and the SPI shift engine (requester 1). Arbitration is round-robin, with an optional bounded burst lock so the SPI engine can stream consecutive words. Each accepted access returns one read-response beat, aligned to the memory's one-cycle registered read. Port B of the memory is untouched.

## Interface
- ADDR_WIDTH, 5, memory word-address width.
- DATA_BYTES, 4, bytes per word; one write enable per byte.
- DATA_WIDTH, DATA_BYTES*8, word width.
- MAX_BURST, 4, maximum consecutive beats a locked owner keeps the port while the other requester waits (≥1).
- clk  in  1  single clock; memory port A runs on it.
- rst  in  1  asynchronous, active-high reset.
- r_valid  in  2  per-requester access request (bit 0 host, bit 1 SPI).
- r_lock  in  2  request to keep ownership for the next beat.
- r_wena  in  2*DATA_BYTES  byte enables; all-zero means read.
- r_addr  in  2*ADDR_WIDTH  word address.
- r_wdata  in  2*DATA_WIDTH  write data.
- r_ready  out  2  access accepted this cycle (combinational, one-hot or zero).
- r_rvalid  out  2  response beat for the access accepted last cycle.
- r_rdata  out  DATA_WIDTH  response data, shared; qualified by r_rvalid.
- mem_wena  out  DATA_BYTES  to memory wena.
- mem_addra  out  ADDR_WIDTH  to memory addra.
- mem_dina  out  DATA_WIDTH  to memory dina.
- mem_douta  in  DATA_WIDTH  from memory douta.

## Operation
- Transfer happens when r_valid[i] && r_ready[i]. At most one r_ready bit is high per cycle. r_ready never depends on r_ready.
- States: ARB, LOCKED (owner index and beat count held).
- ARB:
  - Only one valid: that requester wins.
  - Both valid: the requester other than last_grant wins.
  - last_grant resets to 1, so the host wins the first tie.
- Grant to i with r_lock[i]=1 → LOCKED(owner=i), beat_cnt=1. Otherwise stay in ARB.
- LOCKED:
  - Owner is granted whenever r_valid[owner], regardless of the other requester, until release.
  - Each granted beat increments beat_cnt.
  - Release back to ARB after a granted beat with r_lock[owner]=0.
  - Release after a cycle with r_valid[owner]=0. The port is idle that cycle, and the other requester is not granted.
  - Release after a beat with beat_cnt==MAX_BURST while the other requester is valid.
  - If the other requester is idle, the count saturates at MAX_BURST and the lock persists.
- last_grant updates on every grant, in both states.
- Memory drive in a granted cycle: mem_addra/mem_dina/mem_wena = winner's fields.
- Memory drive with no grant: mem_wena=0, mem_addra=0, mem_dina=0.
- Response:
  - r_rvalid[i] is registered: set the cycle after a grant to i, else 0.
  - r_rdata = mem_douta, passed through.
  - Every accepted access, write or read, gets exactly one response.
  - A write returns the pre-write word, because the memory reads before it writes.

## Timing
- Reset values: r_ready=0, r_rvalid=0, mem_wena=0, mem_addra=0, mem_dina=0, state=ARB, last_grant=1, beat_cnt=0. r_rdata follows mem_douta.
- Request-to-grant: 0 cycles (same cycle).
- Grant-to-response: 1 cycle.
- Back-to-back grants every cycle are permitted; responses are 1:1 in order.
- Reset asserted mid-burst: lock dropped, pending r_rvalid cleared (response lost), no memory write in any reset cycle.
- Inputs of a non-granted requester must be held stable by that requester; the arbiter keeps no request queue.

## Structure
- Shared package spi_ctrl_pkg gets:
  - REQ_HOST=0, REQ_SPI=1.
  - typedef enum logic {ARB, LOCKED} arb_state_t.
  - NUM_REQ=2.
- Sub-module spi_mem_rr_pick: combinational 2-way round-robin select, taking valid and last_grant and producing a one-hot grant. It is reusable by the port-B scheduler.
- Beat counter width: $clog2(MAX_BURST+1).

## Test plan
- Reset release, host read addr 3 (memory preloaded 0xA5A5_0003) → r_ready[0] same cycle, r_rvalid[0] next cycle with r_rdata=0xA5A5_0003.
- Both valid continuously, no lock → grants alternate 0,1,0,1; first grant to host; r_rvalid one cycle behind each.
- Host writes wena=4'b0010, data 0x0000_BB00, to word 0x1122_3344 → response returns 0x1122_3344; a following read returns 0x1122_BB44.
- SPI locked burst with host also valid, MAX_BURST=4 → SPI gets 4 consecutive grants, host granted on the 5th cycle, SPI again after that.
- SPI locked, drops r_valid for one cycle while the host is valid → no grant that cycle; host granted the next cycle.
- Reset asserted on the cycle after a grant → r_rvalid stays 0, state=ARB, mem_wena=0 throughout reset.

Source files
------------

// File: rtl/spi_ctrl_pkg.sv
// Shared types and constants for the SPI controller memory-port logic.
// Requester indices and the arbiter state encoding live here.
package spi_ctrl_pkg;

  localparam int NUM_REQ  = 2;
  localparam int REQ_HOST = 0;
  localparam int REQ_SPI  = 1;

  typedef enum logic {
    ARB,
    LOCKED
  } arb_state_t;

endpackage

// File: rtl/spi_mem_rr_pick.sv
// Two-way round-robin selector: one-hot grant from the valid vector,
// and on a tie it favours the requester that did not win last.
module spi_mem_rr_pick
  import spi_ctrl_pkg::*;
(
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic               last_grant_i,
  output logic [NUM_REQ-1:0] grant_o
);

  always_comb begin
    grant_o = '0;
    case (valid_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = last_grant_i ? 2'b01 : 2'b10;
      default: grant_o = '0;
    endcase
  end

endmodule

// File: rtl/spi_mem_port_arbiter.sv
// Round-robin arbiter for memory port A between the host bridge and the SPI
// shift engine, with a bounded burst lock and a one-beat registered response.
module spi_mem_port_arbiter
  import spi_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_BYTES = 4,
  parameter int DATA_WIDTH = DATA_BYTES * 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            r_valid,
  input  logic [NUM_REQ-1:0]            r_lock,
  input  logic [NUM_REQ*DATA_BYTES-1:0] r_wena,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] r_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] r_wdata,
  output logic [NUM_REQ-1:0]            r_ready,
  output logic [NUM_REQ-1:0]            r_rvalid,
  output logic [DATA_WIDTH-1:0]         r_rdata,
  output logic [DATA_BYTES-1:0]         mem_wena,
  output logic [ADDR_WIDTH-1:0]         mem_addra,
  output logic [DATA_WIDTH-1:0]         mem_dina,
  input  logic [DATA_WIDTH-1:0]         mem_douta
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

  arb_state_t         state_q, state_d;
  logic               owner_q, owner_d;
  logic               last_grant_q, last_grant_d;
  logic [CNT_W-1:0]   beat_q, beat_d;
  logic [NUM_REQ-1:0] rvalid_q;

  logic [NUM_REQ-1:0] rr_grant;
  logic [NUM_REQ-1:0] grant_raw;
  logic [NUM_REQ-1:0] grant;
  logic               arb_win;
  logic [CNT_W-1:0]   beat_inc;

  spi_mem_rr_pick u_rr_pick (
    .valid_i      (r_valid),
    .last_grant_i (last_grant_q),
    .grant_o      (rr_grant)
  );

  assign arb_win  = rr_grant[REQ_SPI];
  assign beat_inc = (beat_q == MAX_CNT) ? MAX_CNT : beat_q + ONE_CNT;

  // Next-state logic; the lock is released by a dropped request, a cleared
  // lock bit, or a full burst while the other requester is waiting.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    beat_d       = beat_q;
    grant_raw    = '0;

    case (state_q)
      ARB: begin
        grant_raw = rr_grant;
        beat_d    = '0;
        if (|rr_grant) begin
          last_grant_d = arb_win;
          if (r_lock[arb_win] && !(MAX_BURST == 1 && r_valid[~arb_win])) begin
            state_d = LOCKED;
            owner_d = arb_win;
            beat_d  = ONE_CNT;
          end
        end
      end

      LOCKED: begin
        if (r_valid[owner_q]) begin
          grant_raw[owner_q] = 1'b1;
          last_grant_d       = owner_q;
          beat_d             = beat_inc;
          if (!r_lock[owner_q] || (beat_inc == MAX_CNT && r_valid[~owner_q])) begin
            state_d = ARB;
            beat_d  = '0;
          end
        end else begin
          state_d = ARB;
          beat_d  = '0;
        end
      end

      default: begin
        state_d = ARB;
        beat_d  = '0;
      end
    endcase
  end

  // No grant may reach the memory while reset is held.
  assign grant   = rst ? '0 : grant_raw;
  assign r_ready = grant;

  always_comb begin
    mem_wena  = '0;
    mem_addra = '0;
    mem_dina  = '0;
    if (grant[REQ_HOST]) begin
      mem_wena  = r_wena[REQ_HOST*DATA_BYTES +: DATA_BYTES];
      mem_addra = r_addr[REQ_HOST*ADDR_WIDTH +: ADDR_WIDTH];
      mem_dina  = r_wdata[REQ_HOST*DATA_WIDTH +: DATA_WIDTH];
    end else if (grant[REQ_SPI]) begin
      mem_wena  = r_wena[REQ_SPI*DATA_BYTES +: DATA_BYTES];
      mem_addra = r_addr[REQ_SPI*ADDR_WIDTH +: ADDR_WIDTH];
      mem_dina  = r_wdata[REQ_SPI*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ARB;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      beat_q       <= '0;
      rvalid_q     <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      beat_q       <= beat_d;
      rvalid_q     <= grant;
    end
  end

  assign r_rvalid = rvalid_q;
  assign r_rdata  = mem_douta;

endmodule
